seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier for the ALU. It computes a WIDTH×WIDTH product over WIDTH+1 clock cycles with a start/done handshake, and it supports both signed and unsigned operands at run time. It replaces the combinational array multiplier in the ALU datapath. The ALU controller issues one operation at a time and waits for `done`.

---
 rtl/seq_multiplier_pkg.sv | 21 ++
 rtl/seq_multiplier_add_shift.sv | 19 +
 rtl/seq_multiplier.sv | 94 +++++++++
 tb/tb_seq_multiplier.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared ALU multiplier definitions: FSM states,
// default width and the two's-complement negate helper.
package seq_multiplier_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int NEG_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mul_state_t;

    // Callers zero-extend into NEG_W bits and truncate the result back.
    function automatic logic [NEG_W-1:0] twos_negate(
        input logic [NEG_W-1:0] v
    );
        return ~v + NEG_W'(1);
    endfunction

endpackage

// File: rtl/seq_multiplier_add_shift.sv
// One shift-add iteration: conditional add of the multiplicand
// into the upper field, then a logical right shift.
module mul_add_shift_stage #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] ma,
    output logic [2*WIDTH:0] acc_next
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;

    // Upper field is always below 2^WIDTH here, so the sum cannot wrap.
    assign addend   = acc[0] ? {1'b0, ma} : '0;
    assign sum      = acc[2*WIDTH:WIDTH] + addend;
    assign acc_next = {1'b0, sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned shift-add multiplier,
// WIDTH+1 edges from accepted start to done.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int PW = 2 * WIDTH;

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ma;
    logic             neg;
    logic [PW:0]      acc;
    logic [PW:0]      acc_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    prod_neg;
    logic             last_iter;

    always_comb begin
        a_mag = a;
        b_mag = b;
        if (op_signed && a[WIDTH-1])
            a_mag = WIDTH'(twos_negate(NEG_W'(a)));
        if (op_signed && b[WIDTH-1])
            b_mag = WIDTH'(twos_negate(NEG_W'(b)));
    end

    assign prod_neg  = PW'(twos_negate(NEG_W'(acc[PW-1:0])));
    assign last_iter = (cnt == CNT_W'(WIDTH-1));

    mul_add_shift_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .acc     (acc),
        .ma      (ma),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ma     <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ma    <= a_mag;
                        neg   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= {{(WIDTH+1){1'b0}}, b_mag};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter)
                        state <= FIX;
                end
                FIX: begin
                    result <= neg ? prod_neg : acc[PW-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier (WIDTH=16)
// plus a standalone check of the add/shift stage.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_signed = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_signed(op_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    logic [8:0] st_acc;
    logic [3:0] st_ma;
    logic [8:0] st_next;

    mul_add_shift_stage #(
        .WIDTH(4)
    ) u_st (
        .acc     (st_acc),
        .ma      (st_ma),
        .acc_next(st_next)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op; lat counts edges from the accept edge to done.
    task automatic mul_op(input logic sgn, input logic [15:0] x,
                          input logic [15:0] y, input bit poke,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        start = 1'b1;
        op_signed = sgn;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            if (poke && lat == 4) begin
                start = 1'b1;
                a = 16'h1234;
                b = 16'h4321;
                op_signed = ~sgn;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        r = result;
    endtask

    task automatic op_check(input string tag, input logic sgn,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        mul_op(sgn, x, y, 1'b0, r, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd17);
        chk({tag, "_res"}, 64'(r), 64'(exp));
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] e;
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        int          lat;
        int          seen;

        st_acc = 9'h003; st_ma = 4'hF; #1;
        chk("stage_add", 64'(st_next), 64'h079);
        st_acc = 9'h10A; st_ma = 4'hF; #1;
        chk("stage_noadd", 64'(st_next), 64'h085);
        st_acc = 9'h081; st_ma = 4'hF; #1;
        chk("stage_carry", 64'(st_next), 64'h0B8);

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op_check("u_3x5", 1'b0, 16'd3, 16'd5, 32'h0000000F);
        @(posedge clk); #1;
        chk("done_pulse", 64'(done), 64'd0);
        op_check("u_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        op_check("s_min", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
        op_check("s_m1x1", 1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
        op_check("s_zero", 1'b1, 16'h0000, 16'h8000, 32'h00000000);
        op_check("u_min", 1'b0, 16'h8000, 16'h0002, 32'h00010000);

        mul_op(1'b0, 16'd3, 16'd5, 1'b1, r, lat);
        chk("ign_lat", 64'(lat), 64'd17);
        chk("ign_res", 64'(r), 64'h0000000F);
        @(posedge clk); #1;
        chk("ign_busy", 64'(busy), 64'd0);

        // Second op is driven inside the done cycle of the first.
        op_check("b2b_1", 1'b1, 16'hFFF9, 16'd6, 32'hFFFFFFD6);
        op_check("b2b_2", 1'b0, 16'd1000, 16'd1000, 32'd1000000);

        @(negedge clk);
        start = 1'b1;
        op_signed = 1'b0;
        a = 16'd77;
        b = 16'd99;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_result", 64'(result), 64'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("rstmid_nodone", 64'(seen), 64'd0);
        op_check("after_rst", 1'b1, 16'hFFF9, 16'd6, 32'hFFFFFFD6);

        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            if (s)
                e = 32'($signed(x) * $signed(y));
            else
                e = 32'(x) * 32'(y);
            mul_op(s, x, y, 1'b0, r, lat);
            chk("rand_lat", 64'(lat), 64'd17);
            chk("rand_res", 64'(r), 64'(e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
